// File: rtl/ksa_seq_adder_ctrl.sv
// ksa_seq_adder_ctrl -- multi-cycle wide adder built around one 4-bit
// Kogge-Stone adder (KSA_4bit), processed one nibble at a time.
//
// KSA_4bit has no carry input. Each nibble therefore takes two passes:
//   ADD : a_nibble + b_nibble          -> partial p, carry c1
//   FIX : p + {3'b000, carry}          -> final nibble, carry = c1 | s[4]
// c1 and the FIX carry can never both be set: if a+b overflowed, p <= 14,
// so adding at most 1 cannot overflow again.
//
// Optional build macro: KSA_SEQ_CARRY_SKIP_EN
//   When defined, a nibble entered with carry==0 completes in its ADD pass
//   and the FIX pass is skipped. Latency becomes
//   NIBBLES + (number of nibbles entered with carry=1).
//   When undefined, latency is fixed at 2*NIBBLES cycles.
//
// Parameters:
//   NIBBLES   number of 4-bit slices (1..8), W = 4*NIBBLES
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present          in_ready  operands accepted (IDLE)
//   op_a/op_b  W-bit operands            cin       carry seed for nibble 0
//   out_valid  result present (DONE)     out_ready consumer accepts result
//   sum        registered W-bit sum      cout      registered carry-out
//   busy       high while in ADD or FIX

module KSA_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [4:0] s
);
   logic [3:0] g0;
   logic [3:0] p0;
   logic [3:0] g1;
   logic [3:2] p1;
   logic [3:0] g2;

   // Two prefix levels (span 1, span 2) cover all 4 bits.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bit
         assign g0[gi] = a[gi] & b[gi];
         assign p0[gi] = a[gi] ^ b[gi];

         if (gi == 0) begin : g_l1_first
            assign g1[gi] = g0[gi];
         end else begin : g_l1
            assign g1[gi] = g0[gi] | (p0[gi] & g0[gi-1]);
         end

         if (gi < 2) begin : g_l2_pass
            assign g2[gi] = g1[gi];
         end else begin : g_l2
            assign p1[gi] = p0[gi] & p0[gi-1];
            assign g2[gi] = g1[gi] | (p1[gi] & g1[gi-2]);
         end

         if (gi == 0) begin : g_sum_first
            assign s[gi] = p0[gi];
         end else begin : g_sum
            assign s[gi] = p0[gi] ^ g2[gi-1];
         end
      end
   endgenerate

   assign s[4] = g2[3];
endmodule

module ksa_seq_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic                 cin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 busy
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             carry_reg, carry_next;
   logic [W-1:0]     a_reg, a_next;
   logic [W-1:0]     b_reg, b_next;
   logic [3:0]       p_reg, p_next;
   logic             c1_reg, c1_next;
   logic [W-1:0]     sum_reg, sum_next;
   logic             cout_reg, cout_next;

   logic             fix_sel;
   logic             nib_wr;
   logic [3:0]       adder_a;
   logic [3:0]       adder_b;
   logic [4:0]       adder_s;
   logic [3:0]       a_nib [NIBBLES];
   logic [3:0]       b_nib [NIBBLES];

   generate
      for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign a_nib[gi] = a_reg[gi*4 +: 4];
         assign b_nib[gi] = b_reg[gi*4 +: 4];
      end
   endgenerate

   // Adder input mux: operand nibbles in ADD, partial + carry in FIX.
   assign fix_sel = (state_reg == S_FIX);
   assign adder_a = fix_sel ? p_reg : a_nib[idx_reg];
   assign adder_b = fix_sel ? {3'b000, carry_reg} : b_nib[idx_reg];

   KSA_4bit u_ksa (
      .a (adder_a),
      .b (adder_b),
      .s (adder_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         p_reg     <= '0;
         c1_reg    <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         carry_reg <= carry_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         p_reg     <= p_next;
         c1_reg    <= c1_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      carry_next = carry_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      p_next     = p_reg;
      c1_next    = c1_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
      nib_wr     = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (in_valid) begin
               a_next     = op_a;
               b_next     = op_b;
               carry_next = cin;
               idx_next   = '0;
               sum_next   = '0;
               state_next = S_ADD;
            end
         end
         S_ADD: begin
`ifdef KSA_SEQ_CARRY_SKIP_EN
            if (!carry_reg) begin
               // Nothing to fold in: the ADD result is already final.
               nib_wr     = 1'b1;
               carry_next = adder_s[4];
               if (idx_reg == LAST_IDX) begin
                  cout_next  = adder_s[4];
                  state_next = S_DONE;
               end else begin
                  idx_next   = idx_reg + IDX_W'(1);
                  state_next = S_ADD;
               end
            end else begin
               p_next     = adder_s[3:0];
               c1_next    = adder_s[4];
               state_next = S_FIX;
            end
`else
            p_next     = adder_s[3:0];
            c1_next    = adder_s[4];
            state_next = S_FIX;
`endif
         end
         S_FIX: begin
            nib_wr     = 1'b1;
            carry_next = c1_reg | adder_s[4];
            if (idx_reg == LAST_IDX) begin
               cout_next  = c1_reg | adder_s[4];
               state_next = S_DONE;
            end else begin
               idx_next   = idx_reg + IDX_W'(1);
               state_next = S_ADD;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      for (int i = 0; i < NIBBLES; i++) begin
         if (nib_wr && (idx_reg == IDX_W'(i))) begin
            sum_next[i*4 +: 4] = adder_s[3:0];
         end
      end
   end

   // rst_n gates in_ready so the upstream never sees a handshake during reset.
   assign in_ready  = rst_n && (state_reg == S_IDLE);
   assign out_valid = (state_reg == S_DONE);
   assign busy      = (state_reg == S_ADD) || (state_reg == S_FIX);
   assign sum       = sum_reg;
   assign cout      = cout_reg;
endmodule

// File: doc/ksa_seq_adder_ctrl.md
Name: ksa_seq_adder_ctrl

Overview:
- Multi-cycle wide adder controller that reuses a single `KSA_4bit` instance, one nibble at a time.
- `KSA_4bit` has no carry-in, so each nibble is resolved in two passes:
  - ADD pass: a + b.
  - FIX pass: partial sum + incoming carry.
- Accepts operands over a valid/ready handshake and returns the registered sum and carry-out over a second valid/ready handshake.
- Serves as the accumulation stage for the vedic multiplier partial-product merge.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 1..8).

Ports:
- clk        in   1   clock, rising edge
- rst_n      in   1   asynchronous active-low reset
- in_valid   in   1   operands present
- in_ready   out  1   controller can accept operands
- op_a       in   W   operand A
- op_b       in   W   operand B
- cin        in   1   carry-in seed for nibble 0
- out_valid  out  1   result present
- out_ready  in   1   consumer accepts result
- sum        out  W   registered sum
- cout       out  1   registered carry-out
- busy       out  1   high in ADD or FIX

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE, in_ready=0 during reset, out_valid=0, sum=0, cout=0, busy=0, internal nibble index/carry/operand registers=0.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op_a, op_b, cin into carry reg; idx=0; go to ADD.
- State ADD (busy=1):
  - Adder inputs are A[idx], B[idx].
  - Register p=s[3:0] and c1=s[4].
  - Go to FIX.
- State FIX (busy=1):
  - Adder inputs are p and {3'b000, carry}.
  - Write nibble idx of sum register = s[3:0].
  - carry <= c1 | s[4]. c1 and s[4] are never both 1; the bench asserts this.
  - If idx==NIBBLES-1: cout <= new carry, go to DONE. Otherwise idx++ and go to ADD.
- State DONE:
  - out_valid=1; sum and cout are stable.
  - On out_ready: out_valid drops and state goes to IDLE.
  - in_ready is 0 throughout DONE; there is no same-cycle restart.
- Latency (macro off): out_valid rises exactly 2*NIBBLES cycles after the input handshake edge.
- Throughput: one operation per 2*NIBBLES+2 cycles, with out_ready held high.
- sum and cout update only in FIX and are otherwise held. The sum register is cleared at input acceptance.
- Backpressure: DONE holds indefinitely while out_ready=0; values remain unchanged.
- in_valid during ADD, FIX or DONE is ignored; operands are not re-latched.
- Reset asserted mid-operation aborts immediately. After release, the next operation starts cleanly from IDLE.
- The single `KSA_4bit` is the only adder; no other arithmetic operators on data paths.

Optional Feature:
- Macro: KSA_SEQ_CARRY_SKIP_EN
- Defined:
  - In ADD, if carry==0, FIX is skipped.
  - ADD writes nibble idx = s[3:0] directly, sets carry <= s[4], and advances idx (or goes to DONE on the last nibble).
  - Latency = NIBBLES + (number of nibbles entered with carry=1) cycles.
- Undefined: always two passes per nibble; fixed latency 2*NIBBLES.

Test Plan (NIBBLES=4):
- op_a=0x1234, op_b=0x4321, cin=0, out_ready=1:
  - sum=0x5555, cout=0.
  - out_valid exactly 8 cycles after handshake; 4 cycles with KSA_SEQ_CARRY_SKIP_EN.
- op_a=0xFFFF, op_b=0x0001, cin=0:
  - sum=0x0000, cout=1.
  - Latency 8; 7 with KSA_SEQ_CARRY_SKIP_EN.
- op_a=0x0000, op_b=0x0000, cin=1:
  - sum=0x0001, cout=0, latency 8.
- op_a=0x8F0F, op_b=0x80F1, cin=1, out_ready=0 for 5 cycles after out_valid:
  - sum=0x1001, cout=1, stable while stalled.
  - in_ready=0 until one cycle after the out_ready handshake.
  - A second in_valid pulse during the stall is ignored.
- Start op_a=0xAAAA, op_b=0x5555; pulse rst_n low at the third busy cycle:
  - out_valid, sum, cout, busy go to 0 asynchronously.
  - After release, op_a=0x0003, op_b=0x0004 gives sum=0x0007, cout=0.
- Random sweep of 2000 operand/cin triples against a W+1-bit reference sum, with random out_ready:
  - All results match.
  - c1&s[4] assertion never fires.
